right_shifter_seq_4b: RTL and testbench
=======================================

// Module: right_shifter_seq_4b
// PURPOSE
//  Sequential multi-step right shifter; mirror of the combinational 1x left shift stage.
//  Accepts a parallel word plus a shift amount through a valid/ready handshake.
//  Shifts right one bit per clock, filling from cin and emitting the LSB on ser_out/cout.
//  Pulses done when finished. Sits in the datapath next to the left shifters,
//  feeding serial consumers and divide-by-2^n paths.
// PARAMETERS
//  WIDTH  4  data width in bits
//  CNT_W  3  width of amt and the internal counter; must hold WIDTH (clog2(WIDTH+1))
// PORTS
//  clk       in   1      single clock, rising edge
//  rst_n     in   1      asynchronous, active-low reset
//  in_valid  in   1      request: din/amt are valid
//  in_ready  out  1      block can accept; transfer when in_valid && in_ready
//  din       in   WIDTH  parallel word to shift
//  amt       in   CNT_W  number of right shifts; values > WIDTH saturate to WIDTH
//  cin       in   1      fill bit entering the MSB; sampled at every shift edge
//  out       out  WIDTH  shift register contents; final result while done=1
//  ser_out   out  1      current LSB of out (combinational from register)
//  cout      out  1      last bit shifted out of the LSB; 0 if no shift done yet
//  busy      out  1      high from accept through the done cycle
//  done      out  1      one-cycle completion pulse
// BEHAVIOUR
//  Reset (async, rst_n=0): out=0, cout=0, cnt=0, state=IDLE, busy=0, done=0, in_ready=1.
//  FSM states: IDLE, SHIFT, DONE.
//  IDLE: in_ready=1, busy=0.
//   On accept at edge E0: out<=din, cout<=0, cnt<=min(amt,WIDTH).
//   Next state is SHIFT if cnt!=0, else DONE.
//  SHIFT: in_ready=0, busy=1. Each edge: out<={cin,out[WIDTH-1:1]}, cout<=out[0], cnt<=cnt-1.
//   Go to DONE on the edge where cnt==1.
//  DONE: done=1, busy=1, in_ready=0 for exactly one cycle; then IDLE.
//   out and cout hold until the next accept.
//  Latency: for n=min(amt,WIDTH), shifts occur at edges E1..En.
//   done is high in the cycle after En (cycle after E0 when n=0).
//   Accept-to-accept minimum is n+2 cycles.
//  in_valid while busy: ignored, no capture, no stall side-effects.
//  amt=0: pass-through, out=din, cout=0.
//  amt>=WIDTH: out becomes all cin copies; cout=din[WIDTH-1].
//  cin changes mid-operation: each shift uses the value present at that edge.
//  rst_n low mid-SHIFT: immediate return to reset values; partial result discarded.
//  No wrap-around: bits leaving the LSB are lost except the latest, held in cout.
// STRUCTURE
//  Shared include shifter_defs.vh holds:
//   state encodings (ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2)
//   WIDTH/CNT_W defaults
//  One sub-module: right_shifter_x1_4b(out, cout, in, cin, sh).
//   Combinational 1-bit right stage built from mux_2x1.
//   sh=1: out={cin,in[3:1]}, cout=in[0]; sh=0: out=in, cout=0.
//  Top level holds:
//   WIDTH-bit register fed by right_shifter_x1_4b (sh=state==SHIFT)
//   load mux for din
//   down-counter
//   3-state FSM
// TESTING
//  1 Reset: rst_n=0 at any time -> out=0000, cout=0, busy=0, done=0, in_ready=1 without a clock edge.
//  2 din=1011, amt=1, cin=0 -> one shift; done high 2 cycles after accept; out=0101, cout=1.
//  3 din=1011, amt=3, cin=1 -> ser_out 1,1,0 per shift; done 4 cycles after accept; out=1111, cout=0.
//  4 din=0110, amt=0 -> done the cycle after accept; out=0110, cout=0, no SHIFT state visited.
//  5 din=1001, amt=7, cin=0 -> saturates to 4 shifts; ser_out 1,0,0,1; out=0000, cout=1.
//  6 Hold in_valid high with new din while busy -> no capture until IDLE; back-to-back accept 1 cycle after done.
//    Then pull rst_n low mid-SHIFT -> outputs zero immediately; restart is clean.

Source files
------------

// File: rtl/right_shifter_seq_4b_pkg.sv
// Purpose: shared types and defaults for the sequential right shifter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: DEF_WIDTH/DEF_CNT_W defaults, FSM state encoding state_t.
package right_shifter_seq_4b_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_CNT_W = 3;   // must be able to hold DEF_WIDTH

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/right_shifter_seq_4b_if.sv
// Purpose: request/result bundle between a producer and the sequential right shifter.
// Latency: n/a (wires only).
// Backpressure: in_valid/in_ready handshake; result side has no backpressure.
// master: drives in_valid, din, amt, cin; slave: drives in_ready, out, ser_out, cout, busy, done.
interface right_shifter_seq_4b_if
    import right_shifter_seq_4b_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] din;
    logic [CNT_W-1:0] amt;
    logic             cin;
    logic [WIDTH-1:0] out;
    logic             ser_out;
    logic             cout;
    logic             busy;
    logic             done;

    modport master (
        output in_valid, din, amt, cin,
        input  in_ready, out, ser_out, cout, busy, done
    );

    modport slave (
        input  in_valid, din, amt, cin,
        output in_ready, out, ser_out, cout, busy, done
    );

endinterface

// File: rtl/mux_2x1.sv
// Purpose: single-bit 2:1 multiplexer, leaf cell of the shift stage.
// Latency: combinational.
// Backpressure: none.
// Ports: a (sel=0), b (sel=1), sel, y.
module mux_2x1 (
    input  logic a,
    input  logic b,
    input  logic sel,
    output logic y
);

    assign y = sel ? b : a;

endmodule

// File: rtl/right_shifter_x1_4b.sv
// Purpose: combinational one-position right shift stage built from mux_2x1 cells.
// Latency: combinational.
// Backpressure: none.
// Ports: in/cin -> out/cout; sh=1 gives out={cin,in[W-1:1]}, cout=in[0]; sh=0 gives out=in, cout=0.
module right_shifter_x1_4b #(
    parameter int WIDTH = 4
) (
    output logic [WIDTH-1:0] out,
    output logic             cout,
    input  logic [WIDTH-1:0] in,
    input  logic             cin,
    input  logic             sh
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        if (i == WIDTH - 1) begin : g_msb
            mux_2x1 u_mux (.a(in[i]), .b(cin),     .sel(sh), .y(out[i]));
        end else begin : g_low
            mux_2x1 u_mux (.a(in[i]), .b(in[i+1]), .sel(sh), .y(out[i]));
        end
    end

    // Without a shift nothing leaves the LSB, so the carry reads as 0.
    mux_2x1 u_cout (.a(1'b0), .b(in[0]), .sel(sh), .y(cout));

endmodule

// File: rtl/right_shifter_seq_4b.sv
// Purpose: loads a word, shifts it right one bit per clock amt times (saturating at WIDTH), pulses done.
// Latency: n=min(amt,WIDTH) shift cycles after accept, then one done cycle; accept-to-accept n+2.
// Backpressure: in_ready low from accept through the done cycle; in_valid while busy is ignored.
// Ports: clk, rst_n (async active-low), bus (slave side of right_shifter_seq_4b_if).
module right_shifter_seq_4b
    import right_shifter_seq_4b_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    right_shifter_seq_4b_if.slave  bus
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             cout_q, cout_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             in_ready_q, in_ready_d;

    logic [WIDTH-1:0] stage_out;
    logic             stage_cout;
    logic [CNT_W-1:0] amt_sat;

    // Shifting past WIDTH only refills with cin, so clamp the count there.
    assign amt_sat = (bus.amt > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : bus.amt;

    right_shifter_x1_4b #(.WIDTH(WIDTH)) u_stage (
        .out  (stage_out),
        .cout (stage_cout),
        .in   (out_q),
        .cin  (bus.cin),
        .sh   (state_q == ST_SHIFT)
    );

    // Status outputs are computed one cycle early so they are registered
    // and line up exactly with the state they describe.
    always_comb begin
        state_d    = state_q;
        out_d      = out_q;
        cout_d     = cout_q;
        cnt_d      = cnt_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        in_ready_d = in_ready_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    out_d      = bus.din;
                    cout_d     = 1'b0;
                    cnt_d      = amt_sat;
                    busy_d     = 1'b1;
                    in_ready_d = 1'b0;
                    if (amt_sat != '0) begin
                        state_d = ST_SHIFT;
                    end else begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            ST_SHIFT: begin
                out_d  = stage_out;
                cout_d = stage_cout;
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
            end
            ST_DONE: begin
                state_d    = ST_IDLE;
                busy_d     = 1'b0;
                in_ready_d = 1'b1;
            end
            default: begin
                state_d    = ST_IDLE;
                busy_d     = 1'b0;
                in_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            out_q      <= '0;
            cout_q     <= 1'b0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            out_q      <= out_d;
            cout_q     <= cout_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign bus.out      = out_q;
    assign bus.ser_out  = out_q[0];
    assign bus.cout     = cout_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.in_ready = in_ready_q;

endmodule

// File: tb/tb_right_shifter_seq_4b.sv
// Purpose: self-checking bench for right_shifter_seq_4b against a behavioural shift model.
// Latency: n/a.
// Backpressure: n/a.
module tb_right_shifter_seq_4b;

    localparam int WIDTH = 4;
    localparam int CNT_W = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   passes = 0;

    right_shifter_seq_4b_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    right_shifter_seq_4b #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Observation vector: {out, cout, ser_out, busy, done, in_ready}
    function automatic logic [8:0] obs_vec();
        return {bus.out, bus.cout, bus.ser_out, bus.busy, bus.done, bus.in_ready};
    endfunction

    function automatic logic pick_cin(int mode);
        if (mode == 2) return 1'($urandom_range(1, 0));
        return (mode == 1);
    endfunction

    // Drives one request and follows it cycle by cycle against the model:
    // the word is divided by 2 per shift with cin entering at weight 8,
    // and the remainder of each division is the carry.
    task automatic run_op(input string tag, input logic [3:0] d, input logic [2:0] a, input int cin_mode);
        int         n;
        int         waited;
        int         m;
        logic       mc;
        logic       c;
        logic [8:0] e;
        n = (int'(a) > WIDTH) ? WIDTH : int'(a);
        waited = 0;
        @(negedge clk);
        while (bus.in_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (bus.in_ready !== 1'b1) $display("FAIL %s ready_wait: in_ready=%b required 1", tag, bus.in_ready);
        else passes++;
        c = pick_cin(cin_mode);
        bus.in_valid = 1'b1;
        bus.din      = d;
        bus.amt      = a;
        bus.cin      = c;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.din      = 4'($urandom);
        bus.amt      = 3'($urandom);
        m  = int'(d);
        mc = 1'b0;
        for (int k = 0; k < n; k++) begin
            e = {4'(m), mc, 1'(m % 2), 1'b1, 1'b0, 1'b0};
            checks++;
            if (obs_vec() !== e) $display("FAIL %s shift%0d: got %b required %b", tag, k, obs_vec(), e);
            else passes++;
            c = pick_cin(cin_mode);
            bus.cin = c;
            @(negedge clk);
            mc = 1'(m % 2);
            m  = m / 2 + (c ? 8 : 0);
        end
        e = {4'(m), mc, 1'(m % 2), 1'b1, 1'b1, 1'b0};
        checks++;
        if (obs_vec() !== e) $display("FAIL %s done: got %b required %b", tag, obs_vec(), e);
        else passes++;
        @(negedge clk);
        e = {4'(m), mc, 1'(m % 2), 1'b0, 1'b0, 1'b1};
        checks++;
        if (obs_vec() !== e) $display("FAIL %s idle: got %b required %b", tag, obs_vec(), e);
        else passes++;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #3;
        checks++;
        if (obs_vec() !== 9'b0000_0_0_0_0_1) $display("FAIL reset: got %b required 000000001", obs_vec());
        else passes++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single_shift();
        run_op("amt1", 4'b1011, 3'd1, 0);
        checks++;
        if ({bus.out, bus.cout} !== 5'b0101_1) $display("FAIL amt1 result: got %b required 01011", {bus.out, bus.cout});
        else passes++;
    endtask

    task automatic test_multi_shift();
        run_op("amt3", 4'b1011, 3'd3, 1);
        checks++;
        if ({bus.out, bus.cout} !== 5'b1111_0) $display("FAIL amt3 result: got %b required 11110", {bus.out, bus.cout});
        else passes++;
    endtask

    task automatic test_pass_through();
        run_op("amt0", 4'b0110, 3'd0, 0);
        checks++;
        if ({bus.out, bus.cout} !== 5'b0110_0) $display("FAIL amt0 result: got %b required 01100", {bus.out, bus.cout});
        else passes++;
    endtask

    task automatic test_saturate();
        run_op("amt7", 4'b1001, 3'd7, 0);
        checks++;
        if ({bus.out, bus.cout} !== 5'b0000_1) $display("FAIL amt7 result: got %b required 00001", {bus.out, bus.cout});
        else passes++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            run_op($sformatf("rand%0d", i), 4'($urandom), 3'($urandom), 2);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        bus.in_valid = 1'b1; bus.din = 4'b1100; bus.amt = 3'd2; bus.cin = 1'b0;
        @(negedge clk);
        // Keep requesting a different word while the first one is in flight.
        bus.din = 4'b1010; bus.amt = 3'd1;
        checks++;
        if ({bus.out, bus.busy, bus.in_ready} !== 6'b1100_1_0) $display("FAIL b2b load: got %b required 110010", {bus.out, bus.busy, bus.in_ready});
        else passes++;
        @(negedge clk);
        checks++;
        if ({bus.out, bus.done} !== 5'b0110_0) $display("FAIL b2b shift1: got %b required 01100", {bus.out, bus.done});
        else passes++;
        @(negedge clk);
        checks++;
        if ({bus.out, bus.cout, bus.done, bus.in_ready} !== 7'b0011_0_1_0) $display("FAIL b2b done: got %b required 0011010", {bus.out, bus.cout, bus.done, bus.in_ready});
        else passes++;
        @(negedge clk);
        checks++;
        if ({bus.out, bus.busy, bus.in_ready} !== 6'b0011_0_1) $display("FAIL b2b idle: got %b required 001101", {bus.out, bus.busy, bus.in_ready});
        else passes++;
        @(negedge clk);
        bus.in_valid = 1'b0;
        checks++;
        if ({bus.out, bus.busy, bus.in_ready} !== 6'b1010_1_0) $display("FAIL b2b reaccept: got %b required 101010", {bus.out, bus.busy, bus.in_ready});
        else passes++;
        @(negedge clk);
        checks++;
        if ({bus.out, bus.cout, bus.done} !== 6'b0101_0_1) $display("FAIL b2b second done: got %b required 010101", {bus.out, bus.cout, bus.done});
        else passes++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_shift();
        @(negedge clk);
        bus.in_valid = 1'b1; bus.din = 4'b1111; bus.amt = 3'd4; bus.cin = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({bus.out, bus.cout, bus.busy} !== 6'b0011_1_1) $display("FAIL midrst pre: got %b required 001111", {bus.out, bus.cout, bus.busy});
        else passes++;
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs_vec() !== 9'b0000_0_0_0_0_1) $display("FAIL midrst async: got %b required 000000001", obs_vec());
        else passes++;
        @(negedge clk);
        rst_n = 1'b1;
        run_op("after_rst", 4'b1010, 3'd2, 1);
        checks++;
        if ({bus.out, bus.cout} !== 5'b1110_1) $display("FAIL after_rst result: got %b required 11101", {bus.out, bus.cout});
        else passes++;
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.din      = '0;
        bus.amt      = '0;
        bus.cin      = 1'b0;
        test_reset();
        test_single_shift();
        test_multi_shift();
        test_pass_through();
        test_saturate();
        test_random();
        test_back_to_back();
        test_reset_mid_shift();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
